// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// Module : rv32i_pkg
// Brief  : Shared RV32I OoO core types: register file widths and ROB entry.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

    localparam int ARCH_REG_FILE_IDX_BW = 5;
    localparam int PHYS_REG_FILE_IDX_BW = 6;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_IDX_BW = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic                            vld;
        logic                            done;
        logic                            dst_vld;
        logic [ARCH_REG_FILE_IDX_BW-1:0] arch_rf_idx;
        logic [PHYS_REG_FILE_IDX_BW-1:0] phys_rf_idx;
    } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rv32i_rob_ptr.sv
//------------------------------------------------------------------------------
// Module : rv32i_rob_ptr
// Brief  : Wrapping ROB pointer with increment and clear (head / tail).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rv32i_rob_ptr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clear,
    input  logic             i_incr,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    // Depth is a power of two, so natural overflow is the wrap.
    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            r_ptr <= '0;
        end else if (i_incr) begin
            r_ptr <= r_ptr + WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/rv32i_reorder_buffer.sv
//------------------------------------------------------------------------------
// Module : rv32i_reorder_buffer
// Brief  : In-order retirement buffer; drives the RF retire interface.
//          Optional flush port enabled by defining ROB_FLUSH_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rv32i_reorder_buffer
    import rv32i_pkg::*;
(
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_alloc,
    input  logic                            i_alloc_dst_vld,
    input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_alloc_arch_rf_idx,
    input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_alloc_phys_rf_idx,
    output logic                            o_alloc_rdy,
    output logic [ROB_IDX_BW-1:0]           o_alloc_rob_idx,
    input  logic                            i_cmpl,
    input  logic [ROB_IDX_BW-1:0]           i_cmpl_rob_idx,
    output logic                            o_retire,
    output logic                            o_retire_dst_vld,
    output logic [ARCH_REG_FILE_IDX_BW-1:0] o_retire_arch_rf_idx,
    output logic [PHYS_REG_FILE_IDX_BW-1:0] o_retire_phys_rf_idx,
    output logic                            o_empty,
`ifdef ROB_FLUSH_EN
    input  logic                            i_flush,
`endif
    output logic [ROB_IDX_BW:0]             o_count
);

    localparam logic [ROB_IDX_BW:0] c_full_count = (ROB_IDX_BW+1)'(ROB_DEPTH);
    localparam logic [ROB_IDX_BW:0] c_one        = (ROB_IDX_BW+1)'(1);

    rob_entry_t                      r_entries [ROB_DEPTH];
    logic [ROB_IDX_BW:0]             r_count;
    logic                            r_empty;
    logic                            r_retire;
    logic                            r_retire_dst_vld;
    logic [ARCH_REG_FILE_IDX_BW-1:0] r_retire_arch_rf_idx;
    logic [PHYS_REG_FILE_IDX_BW-1:0] r_retire_phys_rf_idx;

    logic [ROB_IDX_BW-1:0]           w_head;
    logic [ROB_IDX_BW-1:0]           w_tail;
    logic                            w_flush;
    logic                            w_alloc_rdy;
    logic                            w_alloc_fire;
    logic                            w_retire_fire;
    rob_entry_t                      w_head_entry;
    rob_entry_t                      w_alloc_entry;
    logic [ROB_IDX_BW:0]             w_count_nxt;

`ifdef ROB_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Full is judged by count, never by pointer equality.
    assign w_alloc_rdy   = rstn & (r_count != c_full_count) & ~w_flush;
    assign w_alloc_fire  = i_alloc & w_alloc_rdy;
    assign w_head_entry  = r_entries[w_head];
    assign w_retire_fire = rstn & ~w_flush & w_head_entry.vld & w_head_entry.done;

    always_comb begin
        w_alloc_entry             = '0;
        w_alloc_entry.vld         = 1'b1;
        w_alloc_entry.done        = 1'b0;
        w_alloc_entry.dst_vld     = i_alloc_dst_vld;
        w_alloc_entry.arch_rf_idx = i_alloc_arch_rf_idx;
        w_alloc_entry.phys_rf_idx = i_alloc_phys_rf_idx;
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_alloc_fire && !w_retire_fire) begin
            w_count_nxt = r_count + c_one;
        end else if (!w_alloc_fire && w_retire_fire) begin
            w_count_nxt = r_count - c_one;
        end
    end

    rv32i_rob_ptr #(.WIDTH(ROB_IDX_BW)) u_head_ptr (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (w_flush),
        .i_incr  (w_retire_fire),
        .o_ptr   (w_head)
    );

    rv32i_rob_ptr #(.WIDTH(ROB_IDX_BW)) u_tail_ptr (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (w_flush),
        .i_incr  (w_alloc_fire),
        .o_ptr   (w_tail)
    );

    // Alloc is checked before completion so an alloc overwriting its own index wins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (!rstn || w_flush) begin
                r_entries[i] <= '0;
            end else if (w_alloc_fire && w_tail == ROB_IDX_BW'(i)) begin
                r_entries[i] <= w_alloc_entry;
            end else if (w_retire_fire && w_head == ROB_IDX_BW'(i)) begin
                r_entries[i] <= '0;
            end else if (i_cmpl && i_cmpl_rob_idx == ROB_IDX_BW'(i) && r_entries[i].vld) begin
                r_entries[i].done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || w_flush) begin
            r_count              <= '0;
            r_empty              <= 1'b1;
            r_retire             <= 1'b0;
            r_retire_dst_vld     <= 1'b0;
            r_retire_arch_rf_idx <= '0;
            r_retire_phys_rf_idx <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_retire <= w_retire_fire;
            if (w_retire_fire) begin
                r_retire_dst_vld     <= w_head_entry.dst_vld;
                r_retire_arch_rf_idx <= w_head_entry.arch_rf_idx;
                r_retire_phys_rf_idx <= w_head_entry.phys_rf_idx;
            end else begin
                r_retire_dst_vld     <= 1'b0;
                r_retire_arch_rf_idx <= '0;
                r_retire_phys_rf_idx <= '0;
            end
        end
    end

    assign o_alloc_rdy          = w_alloc_rdy;
    assign o_alloc_rob_idx      = w_tail;
    assign o_retire             = r_retire;
    assign o_retire_dst_vld     = r_retire_dst_vld;
    assign o_retire_arch_rf_idx = r_retire_arch_rf_idx;
    assign o_retire_phys_rf_idx = r_retire_phys_rf_idx;
    assign o_empty              = r_empty;
    assign o_count              = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_reorder_buffer.sv
//------------------------------------------------------------------------------
// Module : tb_rv32i_reorder_buffer
// Brief  : Directed self-checking bench for rv32i_reorder_buffer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv32i_reorder_buffer;
    import rv32i_pkg::*;

    logic                            clk;
    logic                            rstn;
    logic                            i_alloc;
    logic                            i_alloc_dst_vld;
    logic [ARCH_REG_FILE_IDX_BW-1:0] i_alloc_arch_rf_idx;
    logic [PHYS_REG_FILE_IDX_BW-1:0] i_alloc_phys_rf_idx;
    logic                            o_alloc_rdy;
    logic [ROB_IDX_BW-1:0]           o_alloc_rob_idx;
    logic                            i_cmpl;
    logic [ROB_IDX_BW-1:0]           i_cmpl_rob_idx;
    logic                            o_retire;
    logic                            o_retire_dst_vld;
    logic [ARCH_REG_FILE_IDX_BW-1:0] o_retire_arch_rf_idx;
    logic [PHYS_REG_FILE_IDX_BW-1:0] o_retire_phys_rf_idx;
    logic                            o_empty;
    logic [ROB_IDX_BW:0]             o_count;
`ifdef ROB_FLUSH_EN
    logic                            i_flush;
`endif

    int n_vec;
    int n_err;

    rv32i_reorder_buffer u_dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .i_alloc              (i_alloc),
        .i_alloc_dst_vld      (i_alloc_dst_vld),
        .i_alloc_arch_rf_idx  (i_alloc_arch_rf_idx),
        .i_alloc_phys_rf_idx  (i_alloc_phys_rf_idx),
        .o_alloc_rdy          (o_alloc_rdy),
        .o_alloc_rob_idx      (o_alloc_rob_idx),
        .i_cmpl               (i_cmpl),
        .i_cmpl_rob_idx       (i_cmpl_rob_idx),
        .o_retire             (o_retire),
        .o_retire_dst_vld     (o_retire_dst_vld),
        .o_retire_arch_rf_idx (o_retire_arch_rf_idx),
        .o_retire_phys_rf_idx (o_retire_phys_rf_idx),
        .o_empty              (o_empty),
`ifdef ROB_FLUSH_EN
        .i_flush              (i_flush),
`endif
        .o_count              (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs are changed 1ns after a rising edge; outputs sampled at that point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic a, input logic dv, input int arch, input int phys);
        i_alloc             = a;
        i_alloc_dst_vld     = dv;
        i_alloc_arch_rf_idx = ARCH_REG_FILE_IDX_BW'(arch);
        i_alloc_phys_rf_idx = PHYS_REG_FILE_IDX_BW'(phys);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        set_alloc(1'b0, 1'b0, 0, 0);
        i_cmpl         = 1'b0;
        i_cmpl_rob_idx = '0;
`ifdef ROB_FLUSH_EN
        i_flush = 1'b0;
`endif
        tick();
        tick();
        chk("rst_alloc_rdy", 32'(o_alloc_rdy), 0);
        chk("rst_empty",     32'(o_empty), 1);
        chk("rst_count",     32'(o_count), 0);
        chk("rst_retire",    32'(o_retire), 0);
        rstn = 1'b1;
        tick();
        chk("post_rst_rdy", 32'(o_alloc_rdy), 1);

        // 1: three allocations
        for (int i = 0; i < 3; i++) begin
            set_alloc(1'b1, 1'b1, 5 + i, 33 + i);
            chk("alloc_idx", 32'(o_alloc_rob_idx), 32'(i));
            tick();
            chk("t1_no_retire", 32'(o_retire), 0);
        end
        set_alloc(1'b0, 1'b0, 0, 0);
        chk("t1_count", 32'(o_count), 3);
        chk("t1_empty", 32'(o_empty), 0);

        // 2: out-of-order completion, in-order retire
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd2;
        tick();
        i_cmpl = 1'b0;
        tick();
        chk("t2_idx2_held", 32'(o_retire), 0);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd0;
        tick();
        i_cmpl = 1'b0;
        chk("t2_no_bypass", 32'(o_retire), 0);
        tick();
        chk("t2_ret0",      32'(o_retire), 1);
        chk("t2_ret0_phys", 32'(o_retire_phys_rf_idx), 33);
        chk("t2_ret0_arch", 32'(o_retire_arch_rf_idx), 5);
        tick();
        chk("t2_pulse_end", 32'(o_retire), 0);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd1;
        tick();
        i_cmpl = 1'b0;
        tick();
        chk("t2_ret1",      32'(o_retire), 1);
        chk("t2_ret1_phys", 32'(o_retire_phys_rf_idx), 34);
        tick();
        chk("t2_ret2",      32'(o_retire), 1);
        chk("t2_ret2_phys", 32'(o_retire_phys_rf_idx), 35);
        chk("t2_ret2_dv",   32'(o_retire_dst_vld), 1);
        tick();
        chk("t2_ret_end", 32'(o_retire), 0);
        chk("t2_empty",   32'(o_empty), 1);
        chk("t2_count",   32'(o_count), 0);

        // 3: fill, reject extra alloc, retire head, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(1'b1, 1'b1, i + 1, 16 + i);
            tick();
        end
        chk("t3_count_full", 32'(o_count), 16);
        chk("t3_rdy_full",   32'(o_alloc_rdy), 0);
        set_alloc(1'b1, 1'b1, 31, 63);
        tick();
        set_alloc(1'b0, 1'b0, 0, 0);
        chk("t3_extra_ignored", 32'(o_count), 16);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd0;
        tick();
        i_cmpl = 1'b0;
        chk("t3_still_full", 32'(o_alloc_rdy), 0);
        tick();
        chk("t3_ret_head",      32'(o_retire), 1);
        chk("t3_ret_head_phys", 32'(o_retire_phys_rf_idx), 16);
        chk("t3_ret_head_arch", 32'(o_retire_arch_rf_idx), 1);
        chk("t3_rdy_again",     32'(o_alloc_rdy), 1);
        chk("t3_wrap_idx",      32'(o_alloc_rob_idx), 0);
        set_alloc(1'b1, 1'b1, 2, 2);
        tick();
        set_alloc(1'b0, 1'b0, 0, 0);
        chk("t3_refull", 32'(o_count), 16);

        // 4: no-DST entry; alloc beats same-cycle completion
        do_reset();
        set_alloc(1'b1, 1'b0, 9, 40);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd0;
        tick();
        set_alloc(1'b0, 1'b0, 0, 0);
        i_cmpl = 1'b0;
        tick();
        tick();
        chk("t4_alloc_wins", 32'(o_retire), 0);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd0;
        tick();
        i_cmpl = 1'b0;
        tick();
        chk("t4_retire",   32'(o_retire), 1);
        chk("t4_dst_vld",  32'(o_retire_dst_vld), 0);
        tick();
        chk("t4_empty", 32'(o_empty), 1);

        // 5: count 8 with simultaneous alloc + retire; completion to invalid idx
        for (int i = 0; i < 8; i++) begin
            set_alloc(1'b1, 1'b1, i + 1, i + 1);
            tick();
        end
        set_alloc(1'b0, 1'b0, 0, 0);
        chk("t5_count8", 32'(o_count), 8);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd12;
        tick();
        i_cmpl = 1'b0;
        tick();
        chk("t5_inval_cmpl_ret", 32'(o_retire), 0);
        chk("t5_inval_cmpl_cnt", 32'(o_count), 8);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd1;
        tick();
        i_cmpl = 1'b0;
        set_alloc(1'b1, 1'b1, 20, 50);
        tick();
        set_alloc(1'b0, 1'b0, 0, 0);
        chk("t5_sim_retire",      32'(o_retire), 1);
        chk("t5_sim_retire_phys", 32'(o_retire_phys_rf_idx), 1);
        chk("t5_sim_count",       32'(o_count), 8);
        tick();
        chk("t5_count_hold", 32'(o_count), 8);

        // Mid-stream reset with a retire pending on the reset edge
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd2;
        tick();
        i_cmpl = 1'b0;
        rstn = 1'b0;
        tick();
        chk("mrst_no_retire", 32'(o_retire), 0);
        chk("mrst_count",     32'(o_count), 0);
        chk("mrst_empty",     32'(o_empty), 1);
        chk("mrst_rdy",       32'(o_alloc_rdy), 0);
        rstn = 1'b1;
        tick();
        chk("mrst_idx0", 32'(o_alloc_rob_idx), 0);
        tick();
        tick();
        chk("mrst_stays_quiet", 32'(o_retire), 0);

`ifdef ROB_FLUSH_EN
        // 6: flush with entries in flight
        for (int i = 0; i < 5; i++) begin
            set_alloc(1'b1, 1'b1, i + 3, i + 3);
            tick();
        end
        set_alloc(1'b0, 1'b0, 0, 0);
        i_cmpl = 1'b1; i_cmpl_rob_idx = 4'd1;
        tick();
        i_cmpl_rob_idx = 4'd2;
        tick();
        i_cmpl = 1'b0;
        i_flush = 1'b1;
        set_alloc(1'b1, 1'b1, 1, 1);
        chk("t6_rdy_in_flush", 32'(o_alloc_rdy), 0);
        tick();
        i_flush = 1'b0;
        set_alloc(1'b0, 1'b0, 0, 0);
        chk("t6_no_retire", 32'(o_retire), 0);
        chk("t6_count",     32'(o_count), 0);
        chk("t6_empty",     32'(o_empty), 1);
        chk("t6_idx0",      32'(o_alloc_rob_idx), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
